llc_recall_issuer: RTL and testbench

- Initiator side of the LLC owner-recall path.
- Given an eviction or recall candidate line and its per-word owner cache IDs, it groups owned words by owner and issues one revoke request per distinct owner cache.
- It collects revoke responses until every owned word is returned, then pulses done.
- Sits between the LLC lookup/eviction logic, which supplies the owned-word mask and owner IDs, and the LLC-to-cache forward request channel.

---
 rtl/llc_recall_issuer_if.sv | 25 ++
 rtl/llc_recall_issuer.sv | 128 ++++++++++++
 tb/tb_llc_recall_issuer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/llc_recall_issuer_if.sv
// Revoke request/response channel between the LLC recall issuer and the forward network.
interface llc_recall_issuer_if #(
    parameter int unsigned WORDS_PER_LINE  = 4,
    parameter int unsigned CACHE_ID_WIDTH  = 4,
    parameter int unsigned LINE_ADDR_WIDTH = 26
);
    logic                       req_valid;
    logic                       req_ready;
    logic [CACHE_ID_WIDTH-1:0]  req_dest_id;
    logic [WORDS_PER_LINE-1:0]  req_word_mask;
    logic [LINE_ADDR_WIDTH-1:0] req_addr;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [WORDS_PER_LINE-1:0]  rsp_word_mask;

    modport master (
        output req_valid, req_dest_id, req_word_mask, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_word_mask
    );

    modport slave (
        input  req_valid, req_dest_id, req_word_mask, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_word_mask
    );
endinterface

// File: rtl/llc_recall_issuer.sv
// LLC owner-recall initiator: issues one revoke per distinct owner cache of a line
// and waits until every owned word has been returned.
module llc_recall_issuer #(
    parameter int unsigned WORDS_PER_LINE  = 4,
    parameter int unsigned CACHE_ID_WIDTH  = 4,
    parameter int unsigned LINE_ADDR_WIDTH = 26
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [LINE_ADDR_WIDTH-1:0]               line_addr,
    input  logic [WORDS_PER_LINE-1:0]                owned_mask,
    input  logic [WORDS_PER_LINE*CACHE_ID_WIDTH-1:0] owner_ids,
    llc_recall_issuer_if.master                      bus,
    output logic                                     busy,
    output logic                                     done,
    output logic [WORDS_PER_LINE-1:0]                pending_mask
);
    localparam int unsigned W      = WORDS_PER_LINE;
    localparam int unsigned CW     = CACHE_ID_WIDTH;
    localparam int unsigned AW     = LINE_ADDR_WIDTH;
    localparam int unsigned IDS_W  = W * CW;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     to_send_q, to_send_d;
    logic [W-1:0]     pending_q, pending_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [IDS_W-1:0] ids_q, ids_d;

    logic [CW-1:0]    grp_id;
    logic [W-1:0]     grp_mask;
    logic             grp_found;
    logic [W-1:0]     rsp_clear;

    // Owner of the lowest unsent word, plus every unsent word sharing that owner
    always_comb begin
        grp_found = 1'b0;
        grp_id    = '0;
        grp_mask  = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (!grp_found && to_send_q[i]) begin
                grp_found = 1'b1;
                grp_id    = ids_q[i*CW +: CW];
            end
        end
        for (int j = 0; j < int'(W); j++) begin
            grp_mask[j] = to_send_q[j] && (ids_q[j*CW +: CW] == grp_id);
        end
    end

    always_comb begin
        state_d   = state_q;
        to_send_d = to_send_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        ids_d     = ids_q;
        rsp_clear = '0;

        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_clear = bus.rsp_word_mask;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (owned_mask != '0) begin
                        addr_d    = line_addr;
                        ids_d     = owner_ids;
                        to_send_d = owned_mask;
                        pending_d = owned_mask;
                        state_d   = SEND;
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            SEND: begin
                pending_d = pending_q & ~rsp_clear;
                if (bus.req_ready) begin
                    to_send_d = to_send_q & ~grp_mask;
                end
                if (to_send_d == '0) begin
                    state_d = (pending_d == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                pending_d = pending_q & ~rsp_clear;
                if (pending_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            to_send_q <= '0;
            pending_q <= '0;
            addr_q    <= '0;
            ids_q     <= '0;
        end else begin
            state_q   <= state_d;
            to_send_q <= to_send_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            ids_q     <= ids_d;
        end
    end

    // Outputs decode directly from registered state
    assign bus.req_valid     = (state_q == SEND);
    assign bus.req_dest_id   = (state_q == SEND) ? grp_id : '0;
    assign bus.req_word_mask = (state_q == SEND) ? grp_mask : '0;
    assign bus.req_addr      = addr_q;
    assign bus.rsp_ready     = (state_q == SEND) || (state_q == WAIT);
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign pending_mask      = pending_q;
endmodule

// File: tb/tb_llc_recall_issuer.sv
// Directed bench for llc_recall_issuer: grouping, backpressure, responses, early/zero completion, reset abort.
module tb_llc_recall_issuer;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned AW = 26;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     line_addr;
    logic [W-1:0]      owned_mask;
    logic [W*CW-1:0]   owner_ids;
    logic              busy;
    logic              done;
    logic [W-1:0]      pending_mask;

    int errors = 0;
    int checks = 0;

    llc_recall_issuer_if #(.WORDS_PER_LINE(W), .CACHE_ID_WIDTH(CW), .LINE_ADDR_WIDTH(AW)) bus ();

    llc_recall_issuer #(.WORDS_PER_LINE(W), .CACHE_ID_WIDTH(CW), .LINE_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .line_addr    (line_addr),
        .owned_mask   (owned_mask),
        .owner_ids    (owner_ids),
        .bus          (bus.master),
        .busy         (busy),
        .done         (done),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [CW-1:0] id, input logic [W-1:0] m);
        chk({tag, ".valid"}, 32'(bus.req_valid), 32'(v));
        chk({tag, ".dest"},  32'(bus.req_dest_id), 32'(id));
        chk({tag, ".mask"},  32'(bus.req_word_mask), 32'(m));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        line_addr = '0;
        owned_mask = '0;
        owner_ids = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_word_mask = '0;
        #12;
        chk_req("rst", 1'b0, 4'h0, 4'h0);
        chk("rst.busy", 32'(busy), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        chk("rst.pend", 32'(pending_mask), 32'(0));
        chk("rst.rspr", 32'(bus.rsp_ready), 32'(0));
        chk("rst.addr", 32'(bus.req_addr), 32'(0));
        step();
        rst = 1'b1;

        // 1: empty owned mask completes one cycle later without requests
        start = 1'b1; owned_mask = 4'b0000;
        chk("t1.c0.busy", 32'(busy), 32'(0));
        step(); start = 1'b0;
        chk("t1.c1.done", 32'(done), 32'(1));
        chk("t1.c1.busy", 32'(busy), 32'(1));
        chk("t1.c1.valid", 32'(bus.req_valid), 32'(0));
        step();
        chk("t1.c2.done", 32'(done), 32'(0));
        chk("t1.c2.busy", 32'(busy), 32'(0));

        // 2: single owner of the whole line
        start = 1'b1; owned_mask = 4'b1111; owner_ids = 16'h3333;
        line_addr = 26'h1234567; bus.req_ready = 1'b1;
        step(); start = 1'b0;
        chk_req("t2.c1", 1'b1, 4'h3, 4'b1111);
        chk("t2.c1.addr", 32'(bus.req_addr), 32'h1234567);
        chk("t2.c1.pend", 32'(pending_mask), 32'hF);
        step();
        chk_req("t2.c2", 1'b0, 4'h0, 4'h0);
        chk("t2.c2.rspr", 32'(bus.rsp_ready), 32'(1));
        chk("t2.c2.busy", 32'(busy), 32'(1));
        step();
        step();
        bus.rsp_valid = 1'b1; bus.rsp_word_mask = 4'b1111;
        chk("t2.c4.done", 32'(done), 32'(0));
        step(); bus.rsp_valid = 1'b0;
        chk("t2.c5.done", 32'(done), 32'(1));
        chk("t2.c5.pend", 32'(pending_mask), 32'(0));
        step();
        chk("t2.c6.busy", 32'(busy), 32'(0));

        // 3: two owners (w0,w3 -> 2; w1 -> 5), unowned w2 carries a junk id
        start = 1'b1; owned_mask = 4'b1011; owner_ids = 16'h2752; line_addr = 26'h00ABCDE;
        step(); start = 1'b0;
        chk_req("t3.c1", 1'b1, 4'h2, 4'b1001);
        step();
        chk_req("t3.c2", 1'b1, 4'h5, 4'b0010);
        start = 1'b1; owned_mask = 4'b0100; line_addr = 26'h3FFFFFF;
        step(); start = 1'b0;
        chk_req("t3.c3", 1'b0, 4'h0, 4'h0);
        chk("t3.c3.addr", 32'(bus.req_addr), 32'h00ABCDE);
        chk("t3.c3.pend", 32'(pending_mask), 32'b1011);
        bus.rsp_valid = 1'b1; bus.rsp_word_mask = 4'b0010;
        step();
        chk("t3.c4.pend", 32'(pending_mask), 32'b1001);
        bus.rsp_word_mask = 4'b1001;
        step(); bus.rsp_valid = 1'b0;
        chk("t3.c5.pend", 32'(pending_mask), 32'(0));
        chk("t3.c5.done", 32'(done), 32'(1));
        step();
        chk("t3.c6.busy", 32'(busy), 32'(0));

        // 4: backpressure holds the first group stable
        start = 1'b1; owned_mask = 4'b1011; owner_ids = 16'h2752; bus.req_ready = 1'b0;
        step(); start = 1'b0;
        chk_req("t4.c1", 1'b1, 4'h2, 4'b1001);
        step();
        chk_req("t4.c2", 1'b1, 4'h2, 4'b1001);
        step();
        chk_req("t4.c3", 1'b1, 4'h2, 4'b1001);
        step(); bus.req_ready = 1'b1;
        chk_req("t4.c4", 1'b1, 4'h2, 4'b1001);
        step();
        chk_req("t4.c5", 1'b1, 4'h5, 4'b0010);

        // 5: response in same cycle as last request handshake, then a stray response
        bus.rsp_valid = 1'b1; bus.rsp_word_mask = 4'b1001;
        step();
        chk("t5.c6.pend", 32'(pending_mask), 32'b0010);
        chk("t5.c6.busy", 32'(busy), 32'(1));
        chk("t5.c6.valid", 32'(bus.req_valid), 32'(0));
        bus.rsp_word_mask = 4'b0100;
        step(); bus.rsp_valid = 1'b0;
        chk("t5.c7.pend", 32'(pending_mask), 32'b0010);
        chk("t5.c7.done", 32'(done), 32'(0));

        // 6: asynchronous reset while waiting aborts with no done
        rst = 1'b0;
        #1;
        chk("t6.busy", 32'(busy), 32'(0));
        chk("t6.pend", 32'(pending_mask), 32'(0));
        chk("t6.rspr", 32'(bus.rsp_ready), 32'(0));
        chk("t6.addr", 32'(bus.req_addr), 32'(0));
        chk_req("t6", 1'b0, 4'h0, 4'h0);
        step();
        chk("t6.r1.done", 32'(done), 32'(0));
        step();
        rst = 1'b1;
        chk("t6.r2.done", 32'(done), 32'(0));
        start = 1'b1; owned_mask = 4'b0001; owner_ids = 16'h0009; line_addr = 26'h0000042;
        step(); start = 1'b0;
        chk_req("t6.n1", 1'b1, 4'h9, 4'b0001);
        chk("t6.n1.addr", 32'(bus.req_addr), 32'h42);
        step();
        chk("t6.n2.pend", 32'(pending_mask), 32'b0001);
        bus.rsp_valid = 1'b1; bus.rsp_word_mask = 4'b0001;
        step(); bus.rsp_valid = 1'b0;
        chk("t6.n3.done", 32'(done), 32'(1));
        step();
        chk("t6.n4.done", 32'(done), 32'(0));
        chk("t6.n4.busy", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
